// File: rtl/seg_mmio_pkg.sv
// Shared constants, register map and FSM encoding for the seg_mmio block.
package seg_mmio_pkg;

    localparam int CLKDIV_W = 12;
    localparam int SEG_W    = 32;

    // Byte offsets of the four 32-bit registers
    localparam logic [3:0] OFS_DATA = 4'h0;
    localparam logic [3:0] OFS_CTRL = 4'h4;
    localparam logic [3:0] OFS_CNT  = 4'h8;
    localparam logic [3:0] OFS_DIV  = 4'hC;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        R_DATA = 2'd0,
        R_CTRL = 2'd1,
        R_CNT  = 2'd2,
        R_DIV  = 2'd3
    } reg_sel_t;

    // Replace only the bytes of 'old_v' whose strobe bit is set
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++)
            res[b*8 +: 8] = strb[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
        return res;
    endfunction

endpackage

// File: rtl/seg_clkdiv.sv
// Free-running divider counter feeding the display serializer.
module seg_clkdiv
    import seg_mmio_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    output logic [CLKDIV_W-1:0] clkdiv
);

    logic [CLKDIV_W-1:0] r_cnt;

    // Count every cycle out of reset; wraps naturally after all ones
    always_ff @(posedge clk) begin
        if (rst) r_cnt <= '0;
        else     r_cnt <= r_cnt + CLKDIV_W'(1);
    end

    assign clkdiv = r_cnt;

endmodule

// File: rtl/seg_mmio.sv
// Single-outstanding MMIO slave holding the seven-segment display value.
module seg_mmio
    import seg_mmio_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_wen,
    input  logic [3:0]          req_addr,
    input  logic [31:0]         req_wdata,
    input  logic [3:0]          req_wstrb,
    output logic                rsp_valid,
    output logic [31:0]         rsp_rdata,
    input  logic                rsp_ready,
    output logic [CLKDIV_W-1:0] clkdiv,
    output logic [SEG_W-1:0]    num
);

    state_t              r_state, w_next;
    logic [31:0]         r_data;
    logic [1:0]          r_ctrl;      // [0] FREEZE, [1] SHOWCNT
    logic [31:0]         r_cnt;
    logic [31:0]         r_rdata;
    logic [SEG_W-1:0]    r_num;
    logic [CLKDIV_W-1:0] w_clkdiv;
    logic                w_accept;
    reg_sel_t            w_sel;
    logic [31:0]         w_rdata;

    seg_clkdiv u_clkdiv (
        .clk    (clk),
        .rst    (rst),
        .clkdiv (w_clkdiv)
    );

    assign req_ready = (r_state == ST_IDLE) && !rst;
    assign rsp_valid = (r_state == ST_RESP);
    assign w_accept  = req_valid && req_ready;
    assign rsp_rdata = r_rdata;
    assign clkdiv    = w_clkdiv;
    assign num       = r_num;

    // Register decode: the low two address bits fall inside each range
    always_comb begin
        w_sel = R_DIV;
        case (req_addr) inside
            [OFS_DATA : OFS_DATA + 4'd3]: w_sel = R_DATA;
            [OFS_CTRL : OFS_CTRL + 4'd3]: w_sel = R_CTRL;
            [OFS_CNT  : OFS_CNT  + 4'd3]: w_sel = R_CNT;
            default:                      w_sel = R_DIV;
        endcase
    end

    // Read mux; writes return zero
    always_comb begin
        w_rdata = '0;
        if (!req_wen) begin
            case (w_sel)
                R_DATA:  w_rdata = r_data;
                R_CTRL:  w_rdata = {30'd0, r_ctrl};
                R_CNT:   w_rdata = r_cnt;
                default: w_rdata = 32'(w_clkdiv);
            endcase
        end
    end

    // Next-state: one transaction in flight, held until consumed
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)  w_next = ST_RESP;
            default: if (rsp_ready) w_next = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // Write side effects commit on the accept edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
            r_ctrl <= '0;
            r_cnt  <= '0;
        end else if (w_accept && req_wen) begin
            case (w_sel)
                R_DATA: if (req_wstrb != 4'd0) begin
                    r_data <= merge_bytes(r_data, req_wdata, req_wstrb);
                    r_cnt  <= r_cnt + 32'd1;
                end
                R_CTRL: if (req_wstrb[0]) r_ctrl <= req_wdata[1:0];
                default: ;
            endcase
        end
    end

    // Response data captured at accept, held through back-pressure
    always_ff @(posedge clk) begin
        if (rst)           r_rdata <= '0;
        else if (w_accept) r_rdata <= w_rdata;
    end

    // Display value: hold when frozen, else follow the selected source
    always_ff @(posedge clk) begin
        if (rst)            r_num <= '0;
        else if (!r_ctrl[0]) r_num <= r_ctrl[1] ? r_cnt : r_data;
    end

endmodule
